// File: rtl/varint_pkg.sv
// rtl/varint_pkg.sv - shared field-type codes, limits and FSM state type for varint writing
package varint_pkg;

    localparam int MAX_VARINT_BYTES = 10;

    localparam logic [4:0] FT_INT64  = 5'd3;
    localparam logic [4:0] FT_UINT64 = 5'd4;
    localparam logic [4:0] FT_INT32  = 5'd5;
    localparam logic [4:0] FT_BOOL   = 5'd8;
    localparam logic [4:0] FT_UINT32 = 5'd13;
    localparam logic [4:0] FT_ENUM   = 5'd14;
    localparam logic [4:0] FT_SINT32 = 5'd17;
    localparam logic [4:0] FT_SINT64 = 5'd18;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic is_varint(input logic [4:0] ft);
        case (ft)
            FT_INT64, FT_UINT64, FT_INT32, FT_BOOL,
            FT_UINT32, FT_ENUM, FT_SINT32, FT_SINT64: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/varint_encoder.sv
// rtl/varint_encoder.sv - combinational field pre-processing and LEB128 encoding with length
module varint_encoder
    import varint_pkg::*;
(
    input  logic [63:0] value,
    input  logic [4:0]  field_type,
    output logic [7:0]  bytes [MAX_VARINT_BYTES],
    output logic [3:0]  len
);

    logic [63:0] pre;

    always_comb begin
        pre = '0;
        case (field_type)
            FT_SINT32:           pre = {32'b0, {value[30:0], 1'b0} ^ {32{value[31]}}};
            FT_SINT64:           pre = {value[62:0], 1'b0} ^ {64{value[63]}};
            FT_UINT32:           pre = {32'b0, value[31:0]};
            FT_INT32, FT_ENUM:   pre = {{32{value[31]}}, value[31:0]};
            FT_INT64, FT_UINT64: pre = value;
            FT_BOOL:             pre = {63'b0, value[0]};
            default:             pre = '0;
        endcase
    end

    // Length is one more than the highest 7-bit group holding a set bit; zero still takes one byte.
    always_comb begin
        logic [63:0] sh;
        sh  = '0;
        len = 4'd1;
        for (int k = 1; k < MAX_VARINT_BYTES; k++) begin
            if ((pre >> (7 * k)) != 64'd0) len = 4'(k + 1);
        end
        for (int k = 0; k < MAX_VARINT_BYTES; k++) begin
            sh       = pre >> (7 * k);
            bytes[k] = {(4'(k) + 4'd1 < len), sh[6:0]};
        end
    end

endmodule

// File: rtl/varint_lane_writer.sv
// rtl/varint_lane_writer.sv - writes one encoded varint to DRAM in LANES-wide beats with idle gaps
module varint_lane_writer
    import varint_pkg::*;
#(
    parameter int LANES       = 8,
    parameter int ADDR_W      = 64,
    parameter int WAIT_CYCLES = 20
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [63:0]             value,
    input  logic [4:0]              field_type,
    input  logic [ADDR_W-1:0]       dst_addr,
    output logic [LANES-1:0]        dram_en,
    output logic [LANES*ADDR_W-1:0] dram_addr,
    output logic [LANES*8-1:0]      dram_data,
    output logic                    dram_rdwr,
    output logic                    done,
    output logic [3:0]              bytes_written
);

    localparam int WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    state_t             state, next_state;
    logic [3:0]         beat;
    logic [WCW-1:0]     wait_cnt;
    logic [7:0]         cap_bytes [MAX_VARINT_BYTES];
    logic [3:0]         cap_len;
    logic [ADDR_W-1:0]  cap_addr;

    logic [7:0]         enc_bytes [MAX_VARINT_BYTES];
    logic [3:0]         enc_len;
    logic               accept;
    logic               more_beats;

    logic [7:0]         src_bytes [MAX_VARINT_BYTES];
    logic [3:0]         src_len;
    logic [ADDR_W-1:0]  src_addr;
    logic [3:0]         next_beat;

    logic [LANES-1:0]        en_d;
    logic [LANES*ADDR_W-1:0] addr_d;
    logic [LANES*8-1:0]      data_d;

    varint_encoder u_encoder (
        .value      (value),
        .field_type (field_type),
        .bytes      (enc_bytes),
        .len        (enc_len)
    );

    assign accept     = in_valid && (state == ST_IDLE);
    assign more_beats = ((8'(beat) + 8'd1) * 8'(LANES)) < 8'(cap_len);
    assign dram_rdwr  = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (in_valid) next_state = is_varint(field_type) ? ST_WRITE : ST_DONE;
            ST_WRITE: next_state = ST_WAIT;
            ST_WAIT:  if (wait_cnt == WCW'(WAIT_CYCLES - 1))
                          next_state = more_beats ? ST_WRITE : ST_DONE;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            beat      <= '0;
            wait_cnt  <= '0;
            cap_len   <= '0;
            cap_addr  <= '0;
            cap_bytes <= '{default: 8'h00};
        end else begin
            if (accept) begin
                beat      <= '0;
                cap_bytes <= enc_bytes;
                cap_len   <= is_varint(field_type) ? enc_len : 4'd0;
                cap_addr  <= dst_addr;
            end
            if (state == ST_WRITE) wait_cnt <= '0;
            if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
                if (next_state == ST_WRITE) beat <= beat + 4'd1;
            end
        end
    end

    // Outputs are registered, so lane values are built from the beat about to be entered;
    // on the accept edge that means reading the encoder directly rather than the capture.
    always_comb begin
        logic [7:0] idx;
        idx       = '0;
        en_d      = '0;
        addr_d    = '0;
        data_d    = '0;
        src_len   = (state == ST_IDLE) ? (is_varint(field_type) ? enc_len : 4'd0) : cap_len;
        src_addr  = (state == ST_IDLE) ? dst_addr : cap_addr;
        next_beat = (state == ST_IDLE) ? 4'd0 : beat + 4'd1;
        for (int k = 0; k < MAX_VARINT_BYTES; k++)
            src_bytes[k] = (state == ST_IDLE) ? enc_bytes[k] : cap_bytes[k];
        if (next_state == ST_WRITE) begin
            for (int i = 0; i < LANES; i++) begin
                idx = 8'(next_beat) * 8'(LANES) + 8'(i);
                if (idx < {4'b0, src_len}) begin
                    en_d[i]                    = 1'b1;
                    addr_d[i*ADDR_W +: ADDR_W] = src_addr + ADDR_W'(idx);
                    for (int k = 0; k < MAX_VARINT_BYTES; k++)
                        if (idx == 8'(k)) data_d[i*8 +: 8] = src_bytes[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready      <= 1'b1;
            dram_en       <= '0;
            dram_addr     <= '0;
            dram_data     <= '0;
            done          <= 1'b0;
            bytes_written <= '0;
        end else begin
            in_ready  <= (next_state == ST_IDLE);
            dram_en   <= en_d;
            dram_addr <= addr_d;
            dram_data <= data_d;
            done      <= (next_state == ST_DONE);
            if (next_state == ST_DONE) bytes_written <= src_len;
        end
    end

endmodule

// File: tb/tb_varint_lane_writer.sv
// tb/tb_varint_lane_writer.sv - directed and randomized checks of varint_lane_writer against a reference model
module tb_varint_lane_writer;

    localparam int L  = 8;
    localparam int W  = 20;
    localparam int AW = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [63:0]     value;
    logic [4:0]      field_type;
    logic [AW-1:0]   dst_addr;
    logic [L-1:0]    dram_en;
    logic [L*AW-1:0] dram_addr;
    logic [L*8-1:0]  dram_data;
    logic            dram_rdwr;
    logic            done;
    logic [3:0]      bytes_written;

    int checks   = 0;
    int failures = 0;
    int prev_len = 0;
    logic [7:0] exp_bytes [$];
    logic [4:0] ft_list [13] = '{5'd3, 5'd4, 5'd5, 5'd8, 5'd13, 5'd14, 5'd17, 5'd18,
                                 5'd1, 5'd0, 5'd2, 5'd9, 5'd31};

    varint_lane_writer #(.LANES(L), .ADDR_W(AW), .WAIT_CYCLES(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .value         (value),
        .field_type    (field_type),
        .dst_addr      (dst_addr),
        .dram_en       (dram_en),
        .dram_addr     (dram_addr),
        .dram_data     (dram_data),
        .dram_rdwr     (dram_rdwr),
        .done          (done),
        .bytes_written (bytes_written)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: protobuf wire rules applied with plain integer arithmetic.
    function automatic int ref_encode(input logic [63:0] v, input logic [4:0] ft);
        longint unsigned u;
        longint          s64;
        int              s32;
        logic [7:0]      b;
        exp_bytes.delete();
        s32 = int'(v[31:0]);
        s64 = longint'(v);
        case (ft)
            5'd17:       u = (s32 >= 0) ? longint'(s32) * 2 : -longint'(s32) * 2 - 1;
            5'd18:       u = (s64 >= 0) ? s64 * 2 : -s64 * 2 - 1;
            5'd13:       u = {32'b0, v[31:0]};
            5'd5, 5'd14: u = longint'(s32);
            5'd3, 5'd4:  u = v;
            5'd8:        u = {63'b0, v[0]};
            default:     return 0;
        endcase
        do begin
            b = 8'(u % 128);
            u = u / 128;
            if (u != 0) b = b + 8'd128;
            exp_bytes.push_back(b);
        end while (u != 0);
        return exp_bytes.size();
    endfunction

    task automatic run_req(input logic [63:0] v, input logic [4:0] ft,
                           input logic [63:0] a, input bit noise);
        int len, beats, dc, idx;
        logic [L-1:0]    en_e;
        logic [L*AW-1:0] addr_e;
        logic [L*8-1:0]  data_e;
        len   = ref_encode(v, ft);
        beats = (len + L - 1) / L;
        dc    = (len == 0) ? 1 : beats * (1 + W) + 1;
        check("ready_before", in_ready, 1);
        in_valid = 1'b1; value = v; field_type = ft; dst_addr = a;
        @(posedge clk);
        @(negedge clk);
        for (int c = 1; c <= dc; c++) begin
            if (noise && c < dc) begin
                in_valid   = 1'b1;
                value      = {$urandom(), $urandom()};
                field_type = 5'($urandom_range(0, 31));
                dst_addr   = {$urandom(), $urandom()};
            end else begin
                in_valid = 1'b0;
            end
            en_e = '0; addr_e = '0; data_e = '0;
            for (int b = 0; b < beats; b++) begin
                if (c == 1 + b * (1 + W)) begin
                    for (int i = 0; i < L; i++) begin
                        idx = b * L + i;
                        if (idx < len) begin
                            en_e[i]            = 1'b1;
                            addr_e[i*AW +: AW] = a + 64'(idx);
                            data_e[i*8 +: 8]   = exp_bytes[idx];
                        end
                    end
                end
            end
            check("dram_en", dram_en, en_e);
            check("dram_addr", dram_addr, addr_e);
            check("dram_data", dram_data, data_e);
            check("done", done, (c == dc));
            check("in_ready_busy", in_ready, 0);
            check("bytes_written", bytes_written, (c == dc) ? len : prev_len);
            if (c < dc) @(negedge clk);
        end
        prev_len = len;
        @(negedge clk);
        check("done_drop", done, 0);
    endtask

    initial begin
        logic [63:0] rv, ra;
        reset = 1'b1; in_valid = 1'b0; value = '0; field_type = '0; dst_addr = '0;
        repeat (3) @(negedge clk);
        check("rst_en", dram_en, 0);
        check("rst_addr", dram_addr, 0);
        check("rst_data", dram_data, 0);
        check("rst_done", done, 0);
        check("rst_bw", bytes_written, 0);
        check("rst_rdwr", dram_rdwr, 0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", in_ready, 1);

        run_req(64'd300, 5'd4, 64'h1000, 1'b0);
        run_req(64'd0, 5'd4, 64'h2000, 1'b0);
        run_req(64'hFFFF_FFFF, 5'd17, 64'h3000, 1'b0);
        run_req(64'hFFFF_FFFF, 5'd5, 64'h4000, 1'b0);
        run_req(64'hFFFF_FFFF_FFFF_FFFF, 5'd3, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        run_req(64'd1234, 5'd1, 64'h5000, 1'b0);
        run_req(64'd2, 5'd8, 64'h6000, 1'b1);
        run_req(64'hDEAD_BEEF_8000_0000, 5'd13, 64'h7000, 1'b1);
        run_req(64'h8000_0000_0000_0000, 5'd18, 64'h8000, 1'b1);
        run_req(64'h0000_0000_FFFF_FFFE, 5'd14, 64'h9000, 1'b1);

        // Abort a 10-byte request during the first gap.
        in_valid = 1'b1; value = 64'hFFFF_FFFF; field_type = 5'd5; dst_addr = 64'hA000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_ready", in_ready, 1);
        check("abort_bw", bytes_written, 0);
        prev_len = 0;
        for (int c = 0; c < 45; c++) begin
            check("abort_en", dram_en, 0);
            check("abort_done", done, 0);
            @(negedge clk);
        end
        run_req(64'd150, 5'd4, 64'hB000, 1'b0);

        for (int n = 0; n < 40; n++) begin
            rv = {$urandom(), $urandom()} >> $urandom_range(0, 63);
            ra = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15))
                                              : {$urandom(), $urandom()};
            run_req(rv, ft_list[$urandom_range(0, 12)], ra, ($urandom_range(0, 1) == 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/varint_lane_writer.md
VARINT_LANE_WRITER -- requirements
Module: varint_lane_writer

Interface
REQ-001 SHALL have parameter LANES, default 8, giving byte lanes per DRAM write beat (legal values 1, 2, 4, 8, 16).
REQ-002 SHALL have parameter ADDR_W, default 64, giving the DRAM byte-address width.
REQ-003 SHALL have parameter WAIT_CYCLES, default 20, giving idle cycles after each write beat (legal values 1 or more).
REQ-004 SHALL have port clk, input, 1, clock.
REQ-005 SHALL have port reset, input, 1, reset; reset is synchronous and active-high, and the clock is clk.
REQ-006 SHALL have port in_valid, input, 1, request valid.
REQ-007 SHALL have port in_ready, output, 1, block can accept a request.
REQ-008 SHALL have port value, input, 64, raw field value.
REQ-009 SHALL have port field_type, input, 5, protobuf descriptor field type code.
REQ-010 SHALL have port dst_addr, input, ADDR_W, destination byte address of the first encoded byte.
REQ-011 SHALL have port dram_en, output, LANES, per-lane write enable.
REQ-012 SHALL have port dram_addr, output, LANES x ADDR_W, per-lane byte address.
REQ-013 SHALL have port dram_data, output, LANES x 8, per-lane write byte.
REQ-014 SHALL have port dram_rdwr, output, 1, constant 0 (write).
REQ-015 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-016 SHALL have port bytes_written, output, 4, encoded length of the last completed request.

Function
REQ-017 SHALL accept a request on any clock edge where in_valid and in_ready are both 1, capturing value, field_type and dst_addr; in_ready SHALL be 1 only in IDLE.
REQ-018 SHALL pre-process the value by field_type:
- sint32 (17): zigzag of value[31:0], 32-bit result.
- sint64 (18): 64-bit zigzag.
- uint32 (13): value[31:0], zero-extended.
- int32 (5) and enum (14): value[31:0], sign-extended to 64 bits, so a negative value encodes as 10 bytes.
- int64 (3) and uint64 (4): value unchanged.
- bool (8): value[0] only.
REQ-019 SHALL encode the pre-processed value as a LEB128 varint of length len, 1 to 10 bytes; value 0 SHALL encode as the single byte 0x00.
REQ-020 SHALL treat any other field_type as non-varint: the request is accepted, no dram_en is asserted, done pulses, and bytes_written is 0.
REQ-021 SHALL implement the state machine IDLE -> WRITE -> WAIT -> (WRITE | DONE) -> IDLE; a non-varint request goes IDLE -> DONE.
REQ-022 In WRITE for beat b, lane i SHALL be enabled iff b*LANES+i < len.
- dram_addr[i] = dst_addr + b*LANES + i, computed modulo 2^ADDR_W (wrap-around allowed).
- dram_data[i] = encoded byte b*LANES+i.
- Disabled lanes SHALL drive address 0 and data 0.
REQ-023 WRITE SHALL last exactly one cycle; dram_en SHALL be 0 in every other state.
REQ-024 WAIT SHALL last exactly WAIT_CYCLES cycles. It then goes to WRITE with b+1 if (b+1)*LANES < len, otherwise to DONE.
REQ-025 With the accept edge ending cycle 0:
- beat b SHALL be driven in cycle 1 + b*(1+WAIT_CYCLES);
- done SHALL be 1 in cycle beats*(1+WAIT_CYCLES)+1 only, where beats = ceil(len/LANES).
REQ-026 bytes_written SHALL update to len in the DONE cycle and hold until the next DONE.
REQ-027 in_valid asserted while not in IDLE SHALL be ignored, with no effect on the state or the captured data.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 On reset, in any state and including mid-request, the next state SHALL be IDLE.
- dram_en, dram_addr, dram_data, dram_rdwr, done, bytes_written and the beat and wait counters SHALL be 0.
- in_ready SHALL be 1 in the cycle after reset deasserts.
- No done pulse SHALL be produced for an aborted request.

Structure
REQ-030 A shared package varint_pkg SHALL hold the field-type code constants, MAX_VARINT_BYTES = 10, and the state enum type.
REQ-031 The zigzag, masking and LEB128 logic with length computation SHALL be the combinational sub-module varint_encoder, with outputs bytes[10][8] and len[4]; varint_lane_writer holds only the FSM, counters and lane muxing.

Verification
REQ-032 LANES=8, W=20, uint64 value=300, dst_addr=0x1000 -> cycle 1: dram_en=0x03, data AC/02 at 0x1000/0x1001; done in cycle 22; bytes_written=2.
REQ-033 uint64 value=0 -> one beat, dram_en=0x01, data 0x00; bytes_written=1.
REQ-034 sint32 value=0xFFFFFFFF (-1) -> single byte 0x01; int32 value=0xFFFFFFFF -> 10 bytes FF x9 then 01.
REQ-035 LANES=8, int64 value=-1, dst_addr=0xFFFF_FFFF_FFFF_FFFC:
- beat 0: 8 lanes, addresses wrapping to 0x0 at lane 4;
- beat 1 in cycle 22: dram_en=0x03, data FF/01;
- done in cycle 43; bytes_written=10.
REQ-036 LANES=4, int32 value=-1 -> three beats with dram_en 0xF, 0xF, 0x3; field_type=1 (double) -> no dram_en, done in cycle 1, bytes_written=0.
REQ-037 reset asserted during beat 0 WAIT of a 10-byte request -> dram_en stays 0, no done, in_ready=1 after reset; a following request completes normally.
